regfile_bulk_param: RTL and testbench

- Parametrised successor to the 8x8 register file.
- DEPTH words of DATA_W bits; two combinational read ports; one synchronous write port.
- Flat snapshot bus of all registers.
- New: a multi-cycle bulk-writeback engine. It loads BULK_N packed words (e.g. a matrix-multiply result vector) into consecutive registers, using a start/busy/done handshake and stalling the normal write port.

---
 rtl/regfile_bulk_param_if.sv | 13 +
 rtl/regfile_bulk_param.sv | 64 ++++++
 tb/tb_regfile_bulk_param.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/regfile_bulk_param_if.sv
// regfile_bulk_param_if: read/write/bulk-writeback bus of the parametrised register file
interface regfile_bulk_param_if #(parameter int DATA_W = 8, ADDR_W = 3, BULK_N = 4);
  logic write;
  logic [ADDR_W-1:0] destreg, srcreg1, srcreg2;
  logic [DATA_W-1:0] wrtData, rdata1, rdata2;
  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat;
  logic [BULK_N*DATA_W-1:0] bulk_data;
  logic bulk_start, bulk_busy, bulk_done, wr_stall;
  modport master(output write, destreg, wrtData, srcreg1, srcreg2, bulk_start, bulk_data,
                 input rdata1, rdata2, regs_flat, bulk_busy, bulk_done, wr_stall);
  modport slave(input write, destreg, wrtData, srcreg1, srcreg2, bulk_start, bulk_data,
                output rdata1, rdata2, regs_flat, bulk_busy, bulk_done, wr_stall);
endinterface

// File: rtl/regfile_bulk_param.sv
// regfile_bulk_param: DEPTH x DATA_W register file with bulk-writeback engine; define
// REGFILE_BYPASS_EN for read-during-write forwarding on rdata1/rdata2.
module regfile_bulk_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BULK_N = 4,
  parameter int BULK_BASE = 0
) (
  input logic clk,
  input logic reset,
  regfile_bulk_param_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int IW = BULK_N > 1 ? $clog2(BULK_N) : 1;
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] rf [DEPTH];
  logic [DATA_W-1:0] sh [BULK_N];
  logic busy, we, last;
  logic [ADDR_W-1:0] baddr;
  assign busy = state == BURST;
  assign we = bus.write & ~busy;
  assign last = idx == IW'(BULK_N - 1);
  // address arithmetic at ADDR_W bits gives the mod-DEPTH wrap for free
  assign baddr = ADDR_W'(BULK_BASE) + ADDR_W'(idx);
  always_comb
    state_n = state == IDLE  ? (bus.bulk_start ? BURST : IDLE) :
              state == BURST ? (last ? DONE : BURST) : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= DATA_W'(i);
      for (int k = 0; k < BULK_N; k++) sh[k] <= '0;
      idx <= '0;
    end else begin
      if (state == IDLE && bus.bulk_start) begin
        for (int k = 0; k < BULK_N; k++) sh[k] <= bus.bulk_data[k*DATA_W +: DATA_W];
        idx <= '0;
      end
      if (busy) begin
        rf[baddr] <= sh[idx];
        idx <= idx + IW'(1);
      end
      if (we) rf[bus.destreg] <= bus.wrtData;
    end
  assign bus.bulk_busy = busy;
  assign bus.bulk_done = state == DONE;
  assign bus.wr_stall = bus.write & busy;
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign bus.regs_flat[g*DATA_W +: DATA_W] = rf[g];
  end
`ifdef REGFILE_BYPASS_EN
  assign bus.rdata1 = we && bus.srcreg1 == bus.destreg ? bus.wrtData :
                      busy && bus.srcreg1 == baddr ? sh[idx] : rf[bus.srcreg1];
  assign bus.rdata2 = we && bus.srcreg2 == bus.destreg ? bus.wrtData :
                      busy && bus.srcreg2 == baddr ? sh[idx] : rf[bus.srcreg2];
`else
  assign bus.rdata1 = rf[bus.srcreg1];
  assign bus.rdata2 = rf[bus.srcreg2];
`endif
endmodule

// File: tb/tb_regfile_bulk_param.sv
// tb_regfile_bulk_param: directed + random checks against a queue-based model of the register file
module tb_regfile_bulk_param;
  logic clk = 0;
  logic reset = 1;
  int vectors = 0;
  int miscompares = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  regfile_bulk_param_if #(.DATA_W(8), .ADDR_W(3), .BULK_N(4)) bus ();
  regfile_bulk_param #(.DATA_W(8), .ADDR_W(3), .BULK_N(4), .BULK_BASE(6)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] mem [8];
  logic [2:0] qa [$];
  logic [7:0] qd [$];
  bit done_m;
  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    qa.delete();
    qd.delete();
    done_m = 0;
  endtask
  // pending bulk writes live in a queue; an edge retires one of them
  task automatic model_edge();
    bit busy = qa.size() > 0;
    bit nd = 0;
    if (busy) begin
      mem[qa.pop_front()] = qd.pop_front();
      nd = qa.size() == 0;
    end else if (!done_m && bus.bulk_start)
      for (int k = 0; k < 4; k++) begin
        qa.push_back(3'((6 + k) % 8));
        qd.push_back(bus.bulk_data[k*8 +: 8]);
      end
    if (bus.write && !busy) mem[bus.destreg] = bus.wrtData;
    done_m = nd;
  endtask
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] flat_m();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = mem[i];
    return f;
  endfunction
  function automatic logic [7:0] rd_m(input logic [2:0] s);
    logic [7:0] r = mem[s];
    if (BYP) begin
      if (bus.write && qa.size() == 0 && s == bus.destreg) r = bus.wrtData;
      else if (qa.size() > 0 && s == qa[0]) r = qd[0];
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".flat"}, bus.regs_flat, flat_m());
    chk({tag, ".busy"}, 64'(bus.bulk_busy), 64'(qa.size() > 0));
    chk({tag, ".done"}, 64'(bus.bulk_done), 64'(done_m));
    chk({tag, ".stall"}, 64'(bus.wr_stall), 64'(bus.write && qa.size() > 0));
    chk({tag, ".rd1"}, 64'(bus.rdata1), 64'(rd_m(bus.srcreg1)));
    chk({tag, ".rd2"}, 64'(bus.rdata2), 64'(rd_m(bus.srcreg2)));
  endtask
  int dones, busys, guard;
  initial begin
    bus.write = 0; bus.destreg = 0; bus.wrtData = 0; bus.srcreg1 = 0; bus.srcreg2 = 0;
    bus.bulk_start = 0; bus.bulk_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    bus.srcreg1 = 5;
    #1;
    chk("reset.flat", bus.regs_flat, 64'h0706050403020100);
    chk("reset.rd1", 64'(bus.rdata1), 64'h05);
    check_all("reset");
    bus.write = 1; bus.destreg = 2; bus.wrtData = 8'hA5; bus.srcreg1 = 2;
    #1;
    chk("wr.same_cycle", 64'(bus.rdata1), BYP ? 64'hA5 : 64'h02);
    cyc();
    bus.write = 0;
    #1;
    chk("wr.after", 64'(bus.rdata1), 64'hA5);
    bus.bulk_data = 32'h44332211; bus.bulk_start = 1;
    cyc();
    bus.bulk_start = 0; bus.bulk_data = $urandom;
    bus.write = 1; bus.destreg = 3; bus.wrtData = 8'hFF; bus.srcreg1 = 3; bus.srcreg2 = 7;
    dones = 0; busys = 0;
    for (int i = 0; i < 5; i++) begin
      bus.bulk_start = (i == 1 || i == 4);
      #1;
      check_all("burst");
      if (i < 4) chk("burst.reg3_held", 64'(bus.regs_flat[3*8 +: 8]), 64'h03);
      dones += bus.bulk_done;
      busys += bus.bulk_busy;
      cyc();
    end
    bus.write = 0; bus.bulk_start = 0;
    #1;
    dones += bus.bulk_done;
    chk("burst.done_pulses", 64'(dones), 64'd1);
    chk("burst.busy_cycles", 64'(busys), 64'd4);
    chk("burst.reg6", 64'(bus.regs_flat[6*8 +: 8]), 64'h11);
    chk("burst.reg7", 64'(bus.regs_flat[7*8 +: 8]), 64'h22);
    chk("burst.reg0", 64'(bus.regs_flat[0*8 +: 8]), 64'h33);
    chk("burst.reg1", 64'(bus.regs_flat[1*8 +: 8]), 64'h44);
    chk("burst.reg3", 64'(bus.regs_flat[3*8 +: 8]), 64'hFF);
    check_all("post_burst");
    for (int n = 0; n < 300; n++) begin
      bus.write = 1'($urandom);
      bus.destreg = 3'($urandom);
      bus.wrtData = 8'($urandom);
      bus.srcreg1 = 3'($urandom);
      bus.srcreg2 = n[0] ? bus.destreg : 3'($urandom);
      bus.bulk_start = $urandom_range(0, 7) == 0;
      bus.bulk_data = $urandom;
      #1;
      check_all("rand");
      cyc();
    end
    bus.write = 0; bus.bulk_start = 0;
    guard = 0;
    while ((qa.size() > 0 || done_m) && guard < 10) begin
      cyc();
      guard++;
    end
    chk("drain.idle", 64'(qa.size() > 0 || done_m), 64'd0);
    bus.bulk_data = 32'hDDCCBBAA; bus.bulk_start = 1;
    cyc();
    bus.bulk_start = 0;
    cyc();
    cyc();
    chk("mid.reg7", 64'(bus.regs_flat[7*8 +: 8]), 64'hBB);
    reset = 1;
    #2;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_all("after_reset");
      cyc();
    end
    chk("after_reset.flat", bus.regs_flat, 64'h0706050403020100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
